// File: rtl/chain_frame_receiver.sv
// ---------------------------------------------------------------------------
// chain_frame_receiver
//
// UART 8N1 front end for the chain-code border decoder. It receives bytes,
// hunts for the 0xA5 sync byte, captures a five-byte header (start row and
// column, perimeter, area), forwards each chain-code byte as a one-cycle
// strobe, checks the trailing XOR checksum and pulses `start` when the frame
// is good.
//
// Ports
//   clk           system clock, all logic on its rising edge
//   reset         asynchronous active-low reset
//   rx            UART serial input (idle high, asynchronous to clk)
//   code          current chain-code byte (bit 0 = first bit on the wire)
//   done_receiver one-cycle strobe, `code` valid
//   start         one-cycle strobe, frame complete and checksum good
//   primeter      perimeter from header
//   area          area from header
//   start_row     start row from header
//   start_col     start column from header
//   frame_error   one-cycle strobe on framing, header or checksum failure
// ---------------------------------------------------------------------------
module chain_frame_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic [7:0]  code,
  output logic        done_receiver,
  output logic        start,
  output logic [7:0]  primeter,
  output logic [11:0] area,
  output logic [6:0]  start_row,
  output logic [6:0]  start_col,
  output logic        frame_error
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0]       SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [1:0] {P_HUNT, P_HDR, P_CODE, P_CHK} parse_state_t;

  // ------------------------------------------------------------------
  // rx synchronizer
  // ------------------------------------------------------------------
  logic rx_meta_reg, rx_sync_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta_reg <= 1'b1;
      rx_sync_reg <= 1'b1;
    end else begin
      rx_meta_reg <= rx;
      rx_sync_reg <= rx_meta_reg;
    end
  end

  // ------------------------------------------------------------------
  // UART receiver
  // ------------------------------------------------------------------
  uart_state_t      uart_state_reg, uart_state_next;
  logic [CNT_W-1:0] clk_cnt_reg, clk_cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic             byte_valid;   // stop bit good, shift_reg holds the byte
  logic             stop_err;     // stop bit sampled low

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uart_state_reg <= U_IDLE;
      clk_cnt_reg    <= '0;
      bit_idx_reg    <= '0;
      shift_reg      <= '0;
    end else begin
      uart_state_reg <= uart_state_next;
      clk_cnt_reg    <= clk_cnt_next;
      bit_idx_reg    <= bit_idx_next;
      shift_reg      <= shift_next;
    end
  end

  always_comb begin
    uart_state_next = uart_state_reg;
    clk_cnt_next    = clk_cnt_reg;
    bit_idx_next    = bit_idx_reg;
    shift_next      = shift_reg;
    byte_valid      = 1'b0;
    stop_err        = 1'b0;
    unique case (uart_state_reg)
      U_IDLE: begin
        clk_cnt_next = '0;
        bit_idx_next = '0;
        if (!rx_sync_reg) uart_state_next = U_START;
      end
      U_START: begin
        // Mid-start-bit resample rejects glitches shorter than half a bit.
        if (clk_cnt_reg == HALF_LAST) begin
          clk_cnt_next    = '0;
          uart_state_next = rx_sync_reg ? U_IDLE : U_DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end
      U_DATA: begin
        if (clk_cnt_reg == BIT_LAST) begin
          clk_cnt_next = '0;
          shift_next   = {rx_sync_reg, shift_reg[7:1]};  // LSB first
          if (bit_idx_reg == 3'd7) begin
            bit_idx_next    = '0;
            uart_state_next = U_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end
      U_STOP: begin
        if (clk_cnt_reg == BIT_LAST) begin
          clk_cnt_next    = '0;
          uart_state_next = U_IDLE;
          if (rx_sync_reg) byte_valid = 1'b1;
          else             stop_err   = 1'b1;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_W'(1);
        end
      end
      default: uart_state_next = U_IDLE;
    endcase
  end

  // ------------------------------------------------------------------
  // Frame parser
  // ------------------------------------------------------------------
  parse_state_t pstate_reg, pstate_next;
  logic [2:0]   hdr_cnt_reg, hdr_cnt_next;
  logic [7:0]   csum_reg, csum_next;
  logic [6:0]   row_sh_reg, row_sh_next;
  logic [6:0]   col_sh_reg, col_sh_next;
  logic [7:0]   per_sh_reg, per_sh_next;
  logic [7:0]   area_lo_reg, area_lo_next;
  logic [9:0]   code_cnt_reg, code_cnt_next;
  logic [7:0]   code_reg, code_next;
  logic         done_reg, done_next;
  logic         start_reg, start_next;
  logic         ferr_reg, ferr_next;
  logic [6:0]   row_reg, row_next;
  logic [6:0]   col_reg, col_next;
  logic [7:0]   per_reg, per_next;
  logic [11:0]  area_reg, area_next;
  logic [9:0]   n_codes;

  // Three bits per chain code, rounded up to whole bytes (max 96).
  assign n_codes = ({2'b00, per_sh_reg} * 10'd3 + 10'd7) >> 3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pstate_reg   <= P_HUNT;
      hdr_cnt_reg  <= '0;
      csum_reg     <= '0;
      row_sh_reg   <= '0;
      col_sh_reg   <= '0;
      per_sh_reg   <= '0;
      area_lo_reg  <= '0;
      code_cnt_reg <= '0;
      code_reg     <= '0;
      done_reg     <= 1'b0;
      start_reg    <= 1'b0;
      ferr_reg     <= 1'b0;
      row_reg      <= '0;
      col_reg      <= '0;
      per_reg      <= '0;
      area_reg     <= '0;
    end else begin
      pstate_reg   <= pstate_next;
      hdr_cnt_reg  <= hdr_cnt_next;
      csum_reg     <= csum_next;
      row_sh_reg   <= row_sh_next;
      col_sh_reg   <= col_sh_next;
      per_sh_reg   <= per_sh_next;
      area_lo_reg  <= area_lo_next;
      code_cnt_reg <= code_cnt_next;
      code_reg     <= code_next;
      done_reg     <= done_next;
      start_reg    <= start_next;
      ferr_reg     <= ferr_next;
      row_reg      <= row_next;
      col_reg      <= col_next;
      per_reg      <= per_next;
      area_reg     <= area_next;
    end
  end

  always_comb begin
    pstate_next   = pstate_reg;
    hdr_cnt_next  = hdr_cnt_reg;
    csum_next     = csum_reg;
    row_sh_next   = row_sh_reg;
    col_sh_next   = col_sh_reg;
    per_sh_next   = per_sh_reg;
    area_lo_next  = area_lo_reg;
    code_cnt_next = code_cnt_reg;
    code_next     = code_reg;
    done_next     = 1'b0;
    start_next    = 1'b0;
    ferr_next     = 1'b0;
    row_next      = row_reg;
    col_next      = col_reg;
    per_next      = per_reg;
    area_next     = area_reg;

    if (stop_err) begin
      // A broken byte anywhere aborts the frame; resynchronise on next sync.
      ferr_next   = 1'b1;
      pstate_next = P_HUNT;
    end else if (byte_valid) begin
      unique case (pstate_reg)
        P_HUNT: begin
          if (shift_reg == SYNC_BYTE) begin
            csum_next    = '0;
            hdr_cnt_next = '0;
            pstate_next  = P_HDR;
          end
        end
        P_HDR: begin
          csum_next    = csum_reg ^ shift_reg;
          hdr_cnt_next = hdr_cnt_reg + 3'd1;
          case (hdr_cnt_reg)
            3'd0: begin
              if (shift_reg[7]) begin
                ferr_next   = 1'b1;
                pstate_next = P_HUNT;
              end else begin
                row_sh_next = shift_reg[6:0];
              end
            end
            3'd1: begin
              if (shift_reg[7]) begin
                ferr_next   = 1'b1;
                pstate_next = P_HUNT;
              end else begin
                col_sh_next = shift_reg[6:0];
              end
            end
            3'd2: per_sh_next  = shift_reg;
            3'd3: area_lo_next = shift_reg;
            default: begin
              // Header outputs are published only here, so they stay
              // stable for the whole frame and afterwards.
              row_next      = row_sh_reg;
              col_next      = col_sh_reg;
              per_next      = per_sh_reg;
              area_next     = {shift_reg[3:0], area_lo_reg};
              code_cnt_next = n_codes;
              pstate_next   = (n_codes == 10'd0) ? P_CHK : P_CODE;
            end
          endcase
        end
        P_CODE: begin
          code_next     = shift_reg;
          done_next     = 1'b1;
          csum_next     = csum_reg ^ shift_reg;
          code_cnt_next = code_cnt_reg - 10'd1;
          if (code_cnt_reg == 10'd1) pstate_next = P_CHK;
        end
        P_CHK: begin
          if (shift_reg == csum_reg) start_next = 1'b1;
          else                       ferr_next  = 1'b1;
          pstate_next = P_HUNT;
        end
        default: pstate_next = P_HUNT;
      endcase
    end
  end

  assign code          = code_reg;
  assign done_receiver = done_reg;
  assign start         = start_reg;
  assign frame_error   = ferr_reg;
  assign start_row     = row_reg;
  assign start_col     = col_reg;
  assign primeter      = per_reg;
  assign area          = area_reg;

endmodule

// File: tb/tb_chain_frame_receiver.sv
// ---------------------------------------------------------------------------
// tb_chain_frame_receiver
//
// Drives UART frames into chain_frame_receiver and compares the observed
// strobe sequence and header outputs against a frame-level reference model
// that parses the transmitted byte stream directly.
// ---------------------------------------------------------------------------
module tb_chain_frame_receiver;

  localparam int CPB = 4;
  localparam logic [9:0] EV_START = {2'd2, 8'h00};
  localparam logic [9:0] EV_ERR   = {2'd3, 8'h00};

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        rx = 1'b1;
  logic [7:0]  code;
  logic        done_receiver;
  logic        start;
  logic [7:0]  primeter;
  logic [11:0] area;
  logic [6:0]  start_row;
  logic [6:0]  start_col;
  logic        frame_error;

  always #5 clk = ~clk;

  chain_frame_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .rx(rx),
    .code(code), .done_receiver(done_receiver), .start(start),
    .primeter(primeter), .area(area), .start_row(start_row),
    .start_col(start_col), .frame_error(frame_error)
  );

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // transmitted stream, observed and expected events
  logic [7:0] s_byte[$];
  bit         s_bad[$];
  logic [9:0] obs_ev[$];
  logic [9:0] exp_ev[$];
  int         checked = 0;
  logic [6:0]  m_row, m_col;
  logic [7:0]  m_per;
  logic [11:0] m_area;

  // ---------------- monitor ----------------
  longint cyc = 0;
  longint last_strobe = -1;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      if (done_receiver) obs_ev.push_back({2'd1, code});
      if (start)         obs_ev.push_back(EV_START);
      if (frame_error)   obs_ev.push_back(EV_ERR);
      if (done_receiver || start || frame_error) begin
        check("one_strobe", 64'($countones({done_receiver, start, frame_error})), 64'd1);
        if (last_strobe >= 0)
          check("strobe_gap", 64'((cyc - last_strobe) >= 10 * CPB), 64'd1);
        last_strobe = cyc;
      end
    end else begin
      last_strobe = -1;
    end
  end

  // ---------------- reference model ----------------
  task automatic run_model();
    int i, k, n;
    logic [7:0] h[5];
    logic [7:0] sum;
    bit ok;
    exp_ev.delete();
    m_row = '0; m_col = '0; m_per = '0; m_area = '0;
    i = 0;
    while (i < s_byte.size()) begin
      if (s_bad[i]) begin exp_ev.push_back(EV_ERR); i++; continue; end
      if (s_byte[i] != 8'hA5) begin i++; continue; end
      i++; ok = 1'b1; sum = 8'h00;
      for (k = 0; k < 5 && ok; k++) begin
        if (i >= s_byte.size()) return;
        if (s_bad[i] || (k < 2 && s_byte[i][7])) begin
          exp_ev.push_back(EV_ERR); ok = 1'b0;
        end else begin
          h[k] = s_byte[i]; sum ^= s_byte[i];
        end
        i++;
      end
      if (!ok) continue;
      m_row = h[0][6:0]; m_col = h[1][6:0]; m_per = h[2];
      m_area = {h[4][3:0], h[3]};
      n = (3 * int'(h[2]) + 7) / 8;
      for (k = 0; k < n && ok; k++) begin
        if (i >= s_byte.size()) return;
        if (s_bad[i]) begin
          exp_ev.push_back(EV_ERR); ok = 1'b0;
        end else begin
          exp_ev.push_back({2'd1, s_byte[i]}); sum ^= s_byte[i];
        end
        i++;
      end
      if (!ok) continue;
      if (i >= s_byte.size()) return;
      if (s_bad[i])              exp_ev.push_back(EV_ERR);
      else if (s_byte[i] == sum) exp_ev.push_back(EV_START);
      else                       exp_ev.push_back(EV_ERR);
      i++;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic send_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int j = 0; j < n; j++) send_bit(1'b1);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad);
    s_byte.push_back(b);
    s_bad.push_back(bad);
    send_bit(1'b0);
    for (int j = 0; j < 8; j++) send_bit(b[j]);
    send_bit(!bad);
    if (bad) idle_bits(12);
  endtask

  logic [7:0] fq[$];

  task automatic send_fq(input int bad_idx);
    for (int j = 0; j < fq.size(); j++) send_byte(fq[j], j == bad_idx);
  endtask

  task automatic checkpoint(input string name);
    int lim;
    run_model();
    check({name, "_nev"}, 64'(obs_ev.size()), 64'(exp_ev.size()));
    lim = (obs_ev.size() < exp_ev.size()) ? obs_ev.size() : exp_ev.size();
    for (int k = checked; k < lim; k++)
      check({name, "_ev"}, 64'(obs_ev[k]), 64'(exp_ev[k]));
    checked = exp_ev.size();
    check({name, "_hdr"}, {30'b0, start_row, start_col, primeter, area},
          {30'b0, m_row, m_col, m_per, m_area});
    $display("[TB] %s: %0d bytes sent, %0d events seen, %0d expected",
             name, s_byte.size(), obs_ev.size(), exp_ev.size());
  endtask

  task automatic load_valid();
    fq = '{8'hA5, 8'h05, 8'h0A, 8'h04, 8'h10, 8'h00, 8'h88, 8'h06, 8'h95};
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int kind, nj, n, bad_idx;
    logic [7:0] b, row, col, per, sum;
    logic [11:0] ar;

    repeat (5) @(posedge clk);
    #1;
    check("reset_outs",
          {19'b0, code, done_receiver, start, frame_error, primeter, area, start_row, start_col},
          64'd0);
    reset = 1'b1;
    idle_bits(2);

    // test 1: nominal frame
    load_valid(); send_fq(-1); idle_bits(3);
    checkpoint("t1_valid");
    check("t1_per", 64'(primeter), 64'd4);
    check("t1_area", 64'(area), 64'h010);
    check("t1_row", 64'(start_row), 64'd5);
    check("t1_col", 64'(start_col), 64'd10);

    // test 2: bad checksum, then a good frame
    load_valid(); fq[8] = 8'h94; send_fq(-1); idle_bits(3);
    checkpoint("t2_badsum");
    load_valid(); send_fq(-1); idle_bits(3);
    checkpoint("t2_recover");

    // test 3: leading junk
    fq = '{8'h00, 8'hFF, 8'h3C}; send_fq(-1);
    load_valid(); send_fq(-1); idle_bits(3);
    checkpoint("t3_junk");

    // test 4: zero perimeter
    fq = '{8'hA5, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03}; send_fq(-1); idle_bits(3);
    checkpoint("t4_per0");
    check("t4_row", 64'(start_row), 64'd1);
    check("t4_per", 64'(primeter), 64'd0);

    // test 5: stop bit low on third header byte
    fq = '{8'hA5, 8'h07, 8'h09, 8'h20}; send_fq(3); idle_bits(3);
    checkpoint("t5_stoperr");
    check("t5_row_held", 64'(start_row), 64'd1);
    check("t5_col_held", 64'(start_col), 64'd2);

    // test 6: reset during first code byte
    fq = '{8'hA5, 8'h05, 8'h0A, 8'h04, 8'h10, 8'h00}; send_fq(-1);
    send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
    reset = 1'b0;
    #1;
    check("t6_reset_outs",
          {19'b0, code, done_receiver, start, frame_error, primeter, area, start_row, start_col},
          64'd0);
    rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    s_byte.delete(); s_bad.delete(); obs_ev.delete(); checked = 0;
    reset = 1'b1;
    idle_bits(2);
    load_valid(); send_fq(-1); idle_bits(3);
    checkpoint("t6_after_reset");

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      fq.delete();
      kind = $urandom_range(0, 9);
      nj = $urandom_range(0, 2);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        fq.push_back(b);
      end
      fq.push_back(8'hA5);
      row = 8'($urandom_range(0, 127));
      col = 8'($urandom_range(0, 127));
      if (kind == 1) row[7] = 1'b1;
      if (kind == 4) col[7] = 1'b1;
      per = (kind == 5) ? 8'd255 : 8'($urandom_range(0, 20));
      ar = 12'($urandom_range(0, 4095));
      fq.push_back(row); fq.push_back(col); fq.push_back(per);
      fq.push_back(ar[7:0]);
      b = {(kind == 6) ? 4'($urandom_range(1, 15)) : 4'h0, ar[11:8]};
      fq.push_back(b);
      sum = row ^ col ^ per ^ ar[7:0] ^ b;
      n = (3 * int'(per) + 7) / 8;
      for (int j = 0; j < n; j++) begin
        b = 8'($urandom_range(0, 255));
        fq.push_back(b);
        sum ^= b;
      end
      if (kind == 2) sum ^= 8'(1 << $urandom_range(0, 7));
      fq.push_back(sum);
      bad_idx = (kind == 3) ? $urandom_range(nj, fq.size() - 1) : -1;
      send_fq(bad_idx);
      idle_bits(3);
      checkpoint($sformatf("rand%0d_k%0d", f, kind));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/chain_frame_receiver.md
# chain_frame_receiver

Serial front end for the chain-code border decoder. Receives a UART 8N1 byte stream, hunts for a frame sync, and captures a header holding start position, perimeter and area. It then forwards each chain-code byte as a one-cycle `code`/`done_receiver` strobe, checks a trailing XOR checksum, and finally pulses `start` so the decoder begins reconstruction.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per UART bit (50 MHz / 115200); must be ≥ 4.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-low reset (asserted when 0). Clears all state asynchronously; release is synchronous to `clk`.
- `rx`  in  1  UART serial input, idle high, asynchronous to `clk`.
- `code`  out  8  current chain-code byte; bit 0 = first code bit on the wire.
- `done_receiver`  out  1  one-cycle strobe: `code` is valid this cycle.
- `start`  out  1  one-cycle strobe: frame complete and checksum good.
- `primeter`  out  8  perimeter from header.
- `area`  out  12  area from header.
- `start_row`  out  7  start row from header.
- `start_col`  out  7  start column from header.
- `frame_error`  out  1  one-cycle strobe on any framing, header or checksum failure.

## Operation
- `rx` passes through a 2-flop synchronizer before use.
- UART RX FSM states:
  - IDLE: wait for `rx` = 0.
  - START: at `CLKS_PER_BIT/2`, resample. If `rx` is 1, return to IDLE (glitch). If 0, go to DATA.
  - DATA: sample 8 bits, one every `CLKS_PER_BIT`, LSB first.
  - STOP: sample the stop bit. If 1, emit a byte-valid internally. If 0, pulse `frame_error`, force the parser to HUNT, and return to IDLE.
- Frame format, in byte order:
  - 0xA5 sync
  - start_row (bit7 must be 0)
  - start_col (bit7 must be 0)
  - primeter
  - area[7:0]
  - {4'b0, area[11:8]}
  - N code bytes, where N = (3·primeter + 7) >> 3, computed in 10 bits (max 96)
  - checksum = XOR of every byte after sync through the last code byte
- Parser FSM, advanced only on byte-valid:
  - HUNT: discard bytes ≠ 0xA5. On 0xA5, clear the checksum accumulator and header counter, then go to HDR.
  - HDR: capture 5 bytes into shadow registers. If bit7 of row or col is 1, pulse `frame_error` and go to HUNT. After byte 5, copy the shadows to `start_row`/`start_col`/`primeter`/`area` and load the code-byte counter with N. Go to CODE, or to CHK if N = 0.
  - CODE: drive each byte on `code`, pulse `done_receiver`, and decrement the counter. When the counter reaches 0, go to CHK.
  - CHK: compare the received byte with the accumulator. On match, pulse `start`; on mismatch, pulse `frame_error`. Either way, return to HUNT.
- Header outputs change only at header-copy time and hold through the whole frame and afterwards, so the decoder sees them stable when it samples at `start`.
- Code bytes already forwarded are not retracted on a later error. The downstream block is reset by the system on `frame_error`.
- An upper nibble of byte 6 ≠ 0 is ignored; it is not an error.

## Timing
- Reset values:
  - `code` = 0, `done_receiver` = 0, `start` = 0, `frame_error` = 0
  - `primeter` = 0, `area` = 0, `start_row` = 0, `start_col` = 0
  - both FSMs in IDLE/HUNT
- Byte latency: `done_receiver` rises exactly 1 cycle after the stop-bit sample cycle. `code` is registered in that same edge.
- `start` rises 1 cycle after the checksum byte's stop-bit sample. `done_receiver` and `start` are never high in the same cycle.
- Code strobes are spaced ≥ 10·`CLKS_PER_BIT` cycles apart. The gap between the last code strobe and `start` is ≥ 10·`CLKS_PER_BIT` (> 15 cycles, as the decoder requires).
- All strobes are exactly 1 cycle wide.
- Reset mid-byte or mid-frame: outputs go to reset values immediately; after release, the block resumes in HUNT.
- A byte arriving in the CHK→HUNT transition cycle is impossible: bytes are ≥ 10 bit-times apart.

## Test plan
- `CLKS_PER_BIT`=4. Send A5 05 0A 04 10 00 88 06 95 -> `primeter`=4, `area`=0x010, `start_row`=5, `start_col`=10 latched. Two `done_receiver` pulses with `code`=0x88 then 0x06. One `start` pulse 1 cycle after the last stop sample. `frame_error` stays 0.
- Same frame with checksum 0x94 -> both code strobes occur, no `start`, one `frame_error` pulse. The next valid frame is accepted normally.
- Send 00 FF 3C then the valid frame -> the leading bytes are ignored in HUNT, and the frame decodes exactly as in test 1.
- Frame with `primeter`=0: A5 01 02 00 00 00 03 -> zero code strobes, `start` pulses after the checksum 0x03.
- Stop bit forced 0 on the third header byte -> `frame_error` pulse, header outputs unchanged from their previous values, parser returns to HUNT.
- Assert `reset`=0 during the first code byte -> all outputs 0 within the same cycle. After release, a complete valid frame produces the correct strobes.
